// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the buffered UART transmit and receive paths.
//   tx_state_t        : transmit scheduler state encoding
//   FRAME_COUNT_WIDTH : width of the completed-frame counter
//   timer_width()     : counter width needed to count 0..clks_per_bit-1
//   index_width()     : counter width needed to index 0..data_width-1
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int FRAME_COUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

    // At least one bit wide so degenerate parameters still give a legal vector.
    function automatic int timer_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

    function automatic int index_width(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_if
//
// Read-side handshake between the TX FIFO and the transmit scheduler.
//   fifo_empty : FIFO empty flag (FIFO -> scheduler)
//   fifo_pop   : one-cycle read strobe (scheduler -> FIFO)
//   fifo_data  : registered read data, valid the cycle after fifo_pop
//
// Modports:
//   master : the scheduler, which owns the pop strobe
//   slave  : the FIFO read port
// -----------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_data;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_pop
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_pop
    );

endinterface

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
//
// Serial bit-period timer shared by the UART TX and RX paths. Counts
// 0..CLKS_PER_BIT-1 and wraps; bit_end marks the last cycle of each period.
//
// Ports:
//   clock   : system clock, rising-edge active
//   reset   : asynchronous active-high reset, counter returns to 0
//   clear   : synchronous hold-at-zero; the period after clear drops
//             starts at count 0
//   bit_end : high during the final cycle of a bit period
// -----------------------------------------------------------------------------
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int            TW       = timer_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST_CNT = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count;

    // Suppressed during clear so a held-off timer never reports a bit end.
    assign bit_end = !clear && (count == LAST_CNT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Transmit-side controller for the buffered UART. Pops a byte from the TX
// FIFO whenever it is non-empty and enabled, then serialises it as
// start bit, data LSB-first, optional even parity, STOP_BITS stop bits.
//
// Parameters:
//   DATA_WIDTH   : data bits per frame (must match the FIFO width)
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   STOP_BITS    : 1 or 2
//
// Ports:
//   clock       : system clock, rising-edge active
//   reset       : asynchronous active-high reset
//   enable      : permits fetching new bytes; a started frame always completes
//   fifo        : TX FIFO read handshake (master modport: pop out, empty/data in)
//   tx          : registered serial output, idles high
//   busy        : registered, high whenever the scheduler is not IDLE
//   frame_count : completed frames, wraps modulo 2^16
//
// Build option:
//   UART_TX_PARITY_EN : when defined, an even-parity bit is sent between the
//                       last data bit and the stop bit(s).
//
// Timing: a pop sampled at edge E puts the FIFO byte on fifo_data for the
// FETCH cycle; it is latched at edge E+1, where tx also falls for START.
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    uart_tx_scheduler_if.master          fifo,
    output logic                         tx,
    output logic                         busy,
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

    localparam int            IW        = index_width(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [IW-1:0]         bit_index;
    logic                  timer_clear;
    logic                  bit_end;

`ifdef UART_TX_PARITY_EN
    logic parity_bit;
`endif

    // The timer is held at zero until START so the start bit gets a full
    // period beginning on the cycle after FETCH.
    assign timer_clear = (state == IDLE) || (state == FETCH);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .bit_end (bit_end)
    );

    // Mealy pop: only from IDLE, only when data is present, never in reset,
    // so the FIFO cannot underflow and no byte is lost to a held reset.
    assign fifo.fifo_pop = (state == IDLE) && enable && !fifo.fifo_empty && !reset;

    // tx is registered, so each transition loads the level of the bit that
    // the next state will drive.
    assign shift_next = shift_reg >> 1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx          <= 1'b1;
            busy        <= 1'b0;
            frame_count <= '0;
            bit_index   <= '0;
            shift_reg   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (fifo.fifo_pop) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end

                FETCH: begin
                    shift_reg  <= fifo.fifo_data;
`ifdef UART_TX_PARITY_EN
                    parity_bit <= ^fifo.fifo_data;
`endif
                    bit_index  <= '0;
                    tx         <= 1'b0;
                    state      <= START;
                end

                START: begin
                    if (bit_end) begin
                        tx    <= shift_reg[0];
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_next;
                        if (bit_index == LAST_DATA) begin
                            bit_index <= '0;
`ifdef UART_TX_PARITY_EN
                            tx        <= parity_bit;
                            state     <= PARITY;
`else
                            tx        <= 1'b1;
                            state     <= STOP;
`endif
                        end else begin
                            bit_index <= bit_index + IW'(1);
                            tx        <= shift_next[0];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx        <= 1'b1;
                        bit_index <= '0;
                        state     <= STOP;
                    end
                end
`endif

                STOP: begin
                    // bit_index is reused to count stop-bit periods.
                    if (bit_end) begin
                        if (bit_index == LAST_STOP) begin
                            bit_index   <= '0;
                            frame_count <= frame_count + FRAME_COUNT_WIDTH'(1);
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            bit_index <= bit_index + IW'(1);
                        end
                    end
                end

                default: begin
                    tx        <= 1'b1;
                    busy      <= 1'b0;
                    bit_index <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
